wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master.sv | 123 ++++++++++++
 tb/tb_wb_cmd_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone command master: takes one command, runs one
// bus cycle (ack or timeout), then holds the response until it is taken.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDRWIDTH      = 17
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST,
  // command side
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADDRWIDTH-1:0] cmd_adr,
  input  logic [3:0]           cmd_sel,
  input  logic [31:0]          cmd_dat,
  // response side
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_dat,
  output logic                 rsp_err,
  // wishbone master side
  output logic [ADDRWIDTH-1:0] WBs_ADR,
  output logic                 WBs_CYC,
  output logic [3:0]           WBs_BYTE_STB,
  output logic                 WBs_WE,
  output logic                 WBs_RD,
  output logic                 WBs_STB,
  output logic [31:0]          WBs_WR_DAT,
  input  logic [31:0]          WBs_RD_DAT,
  input  logic                 WBs_ACK
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  typedef struct packed {
    logic                 we;
    logic [ADDRWIDTH-1:0] adr;
    logic [3:0]           sel;
    logic [31:0]          dat;
  } req_t;

  // Wait counter value on the last permitted bus cycle.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  req_t        req_q;
  logic [15:0] wait_cnt;
  logic        in_bus;
  logic        timeout;

  assign in_bus  = (state_q == BUS);
  assign timeout = (wait_cnt == LAST_WAIT);

  // State register; reset wins over every transition.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/bus outputs; bus outputs depend only on
  // registers so no cmd_* input reaches a WBs_* output combinationally.
  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    WBs_CYC      = 1'b0;
    WBs_STB      = 1'b0;
    WBs_WE       = 1'b0;
    WBs_RD       = 1'b0;
    WBs_ADR      = '0;
    WBs_BYTE_STB = '0;
    WBs_WR_DAT   = '0;
    case (state_q)
      IDLE: begin
        cmd_ready = !WB_RST;
        if (cmd_valid) state_d = BUS;
      end
      BUS: begin
        WBs_CYC      = 1'b1;
        WBs_STB      = 1'b1;
        WBs_WE       = req_q.we;
        WBs_RD       = !req_q.we;
        WBs_ADR      = req_q.adr;
        WBs_BYTE_STB = req_q.sel;
        WBs_WR_DAT   = req_q.dat;
        if (WBs_ACK || timeout) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture, wait counting and response capture. Ack beats a
  // timeout landing on the same edge; acks outside BUS are ignored.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      req_q    <= '0;
      wait_cnt <= '0;
      rsp_dat  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        req_q    <= '{we: cmd_we, adr: cmd_adr, sel: cmd_sel, dat: cmd_dat};
        wait_cnt <= '0;
      end
      if (in_bus) begin
        if (WBs_ACK) begin
          rsp_dat <= req_q.we ? 32'h0 : WBs_RD_DAT;
          rsp_err <= 1'b0;
        end else if (timeout) begin
          rsp_dat <= 32'h0;
          rsp_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a transaction-level reference model
// compared against every output on every falling edge.
module tb_wb_cmd_master;

  localparam int TMO = 8;
  localparam int AW  = 17;

  logic          clk = 1'b0;
  logic          WB_RST;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [3:0]    cmd_sel;
  logic [31:0]   cmd_dat;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_dat;
  logic [AW-1:0] WBs_ADR;
  logic          WBs_CYC, WBs_WE, WBs_RD, WBs_STB;
  logic [3:0]    WBs_BYTE_STB;
  logic [31:0]   WBs_WR_DAT;
  logic [31:0]   WBs_RD_DAT = 32'h0;
  logic          WBs_ACK    = 1'b0;

  wb_cmd_master #(.TIMEOUT_CYCLES(TMO), .ADDRWIDTH(AW)) dut (
    .WB_CLK(clk), .WB_RST(WB_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_BYTE_STB(WBs_BYTE_STB), .WBs_WE(WBs_WE),
    .WBs_RD(WBs_RD), .WBs_STB(WBs_STB), .WBs_WR_DAT(WBs_WR_DAT),
    .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [3:0]    sel;
    logic [31:0]   dat;
  } cmd_t;

  cmd_t        m_cmd   = '0;
  bit          m_busy  = 0;   // a command is out on the bus
  bit          m_hold  = 0;   // a response is waiting to be taken
  int          m_waited = 0;  // bus cycles already spent without ack
  logic [31:0] m_rdat  = 0;
  logic        m_err   = 0;

  always @(posedge clk) begin
    if (WB_RST) begin
      m_busy = 0; m_hold = 0; m_waited = 0; m_rdat = 0; m_err = 0; m_cmd = '0;
    end else if (m_busy) begin
      if (WBs_ACK) begin
        m_busy = 0; m_hold = 1; m_err = 0;
        m_rdat = m_cmd.we ? 32'h0 : WBs_RD_DAT;
      end else if (m_waited + 1 == TMO) begin
        m_busy = 0; m_hold = 1; m_err = 1; m_rdat = 32'h0;
      end else begin
        m_waited++;
      end
    end else if (m_hold) begin
      if (rsp_ready) m_hold = 0;
    end else if (cmd_valid) begin
      m_cmd = '{we: cmd_we, adr: cmd_adr, sel: cmd_sel, dat: cmd_dat};
      m_busy = 1; m_waited = 0;
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmd_ready",    32'(cmd_ready),    32'(!WB_RST && !m_busy && !m_hold));
    chk("WBs_CYC",      32'(WBs_CYC),      32'(m_busy));
    chk("WBs_STB",      32'(WBs_STB),      32'(m_busy));
    chk("WBs_WE",       32'(WBs_WE),       32'(m_busy && m_cmd.we));
    chk("WBs_RD",       32'(WBs_RD),       32'(m_busy && !m_cmd.we));
    chk("WBs_ADR",      32'(WBs_ADR),      32'(m_busy ? m_cmd.adr : 17'h0));
    chk("WBs_BYTE_STB", 32'(WBs_BYTE_STB), 32'(m_busy ? m_cmd.sel : 4'h0));
    chk("WBs_WR_DAT",   WBs_WR_DAT,        m_busy ? m_cmd.dat : 32'h0);
    chk("rsp_valid",    32'(rsp_valid),    32'(m_hold));
    chk("rsp_dat",      rsp_dat,           m_rdat);
    chk("rsp_err",      32'(rsp_err),      32'(m_err));
  end

  // ---------------- slave ----------------
  bit          slv_en    = 1;
  bit          slv_echo  = 0;
  bit          stray_ack = 0;
  int          slv_wait  = 0;
  int          slv_cnt   = 0;
  logic [31:0] slv_rdat  = 32'h0;

  always @(negedge clk) begin
    if (WBs_STB) begin
      WBs_ACK    = slv_en && (slv_cnt == slv_wait);
      WBs_RD_DAT = slv_echo ? {16'hA5A5, WBs_ADR[15:0]} : slv_rdat;
      slv_cnt++;
    end else begin
      WBs_ACK    = stray_ack;
      WBs_RD_DAT = 32'hBAD0BAD0;
      slv_cnt    = 0;
    end
  end

  // Response collector for the back-to-back run.
  bit          mon_en = 0;
  logic [31:0] rsp_q[$];

  always @(negedge clk) if (mon_en && rsp_valid && rsp_ready) rsp_q.push_back(rsp_dat);

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
    cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
  endtask

  // Presents a command to an idle DUT; returns in the first BUS cycle.
  task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
    @(posedge clk); #1;
    drive(we, adr, sel, dat);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  // Counts STB/RD cycles until rsp_valid; returns on that falling edge.
  task automatic wait_rsp(output int stb_n, output int rd_n);
    stb_n = 0; rd_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
      if (WBs_STB) stb_n++;
      if (WBs_RD)  rd_n++;
    end
    n_chk++; n_fail++;
    $display("FAIL rsp_wait: rsp_valid not seen within 40 cycles");
  endtask

  // Called on a falling edge with rsp_valid high.
  task automatic pop();
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  logic          b_we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [AW-1:0] b_adr[4] = '{17'h100, 17'h104, 17'h108, 17'h10C};
  logic [31:0]   b_exp[4] = '{32'hA5A50100, 32'h0, 32'hA5A50108, 32'hA5A5010C};
  int            acc[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int stb_n, rd_n, k;
    WB_RST = 1; rsp_ready = 0;
    // A command offered during reset must not be taken.
    drive(1, 17'h1, 4'hF, 32'h11111111);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    @(posedge clk); #1;
    WB_RST = 0; cmd_valid = 0;
    @(negedge clk);
    chk("rel_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rel_cyc",       32'(WBs_CYC),   32'h0);
    chk("rel_rsp_valid", 32'(rsp_valid), 32'h0);

    // Zero-wait write.
    slv_wait = 0;
    issue(1, 17'h00010, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_cyc",  32'(WBs_CYC), 32'h1);
    chk("wr_we",   32'(WBs_WE),  32'h1);
    chk("wr_rd",   32'(WBs_RD),  32'h0);
    chk("wr_adr",  32'(WBs_ADR), 32'h10);
    chk("wr_dat",  WBs_WR_DAT,   32'hDEADBEEF);
    @(negedge clk);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_dat",   rsp_dat,        32'h0);
    chk("wr_rsp_err",   32'(rsp_err),   32'h0);
    chk("wr_cyc_off",   32'(WBs_CYC),   32'h0);
    pop();

    // Read with three wait states.
    slv_wait = 3; slv_rdat = 32'h12345678;
    issue(0, 17'h00004, 4'hF, 32'h0);
    wait_rsp(stb_n, rd_n);
    chk("rd_rd_cycles", 32'(rd_n), 32'd4);
    chk("rd_rsp_dat",   rsp_dat,   32'h12345678);
    chk("rd_rsp_err",   32'(rsp_err), 32'h0);
    pop();

    // Timeout, then held under backpressure with stray acks and a waiting command.
    slv_en = 0;
    issue(0, 17'h1ABCD, 4'h3, 32'h0);
    wait_rsp(stb_n, rd_n);
    chk("to_stb_cycles", 32'(stb_n), 32'd8);
    chk("to_rsp_err",    32'(rsp_err), 32'h1);
    chk("to_rsp_dat",    rsp_dat,      32'h0);
    stray_ack = 1;
    drive(1, 17'h55, 4'hF, 32'h77777777);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_err",   32'(rsp_err),   32'h1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      chk("bp_cyc",       32'(WBs_CYC),   32'h0);
    end
    cmd_valid = 0;
    pop();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ack_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("idle_ack_cyc",       32'(WBs_CYC),   32'h0);
      chk("idle_ack_err_held",  32'(rsp_err),   32'h1);
    end
    stray_ack = 0;

    // Ack on the last permitted cycle wins over the timeout.
    slv_en = 1; slv_wait = TMO - 1; slv_rdat = 32'hCAFEF00D;
    issue(0, 17'h00008, 4'hF, 32'h0);
    wait_rsp(stb_n, rd_n);
    chk("late_stb_cycles", 32'(stb_n), 32'd8);
    chk("late_rsp_err",    32'(rsp_err), 32'h0);
    chk("late_rsp_dat",    rsp_dat,      32'hCAFEF00D);
    pop();

    // Zero byte enables still run a full bus cycle.
    slv_wait = 1;
    issue(1, 17'h0FFFF, 4'h0, 32'h55AA55AA);
    wait_rsp(stb_n, rd_n);
    chk("sel0_stb_cycles", 32'(stb_n), 32'd2);
    chk("sel0_rsp_err",    32'(rsp_err), 32'h0);
    pop();

    // Reset in the second bus cycle drops the command.
    slv_en = 0;
    issue(0, 17'h00020, 4'hF, 32'h0);
    @(negedge clk);
    chk("mid_cyc_on", 32'(WBs_CYC), 32'h1);
    @(posedge clk); #1;
    WB_RST = 1;
    @(posedge clk); #1;
    WB_RST = 0;
    @(negedge clk);
    chk("mid_cyc_off",   32'(WBs_CYC),   32'h0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
    end

    // Back-to-back, zero-wait, ready held high.
    slv_en = 1; slv_wait = 0; slv_echo = 1;
    rsp_q.delete();
    @(posedge clk); #1;
    mon_en = 1; rsp_ready = 1;
    drive(b_we[0], b_adr[0], 4'hF, 32'h0);
    k = 0;
    for (int g = 0; g < 40 && k < 4; g++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc[k] = cyc;
        k++;
        @(posedge clk); #1;
        if (k < 4) drive(b_we[k], b_adr[k], 4'hF, 32'h0);
        else       cmd_valid = 0;
      end
    end
    chk("b2b_accepts", 32'(k), 32'd4);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
    repeat (6) @(negedge clk);
    chk("b2b_rsp_count", 32'(rsp_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rsp_q.size(); i++) chk("b2b_rsp_dat", rsp_q[i], b_exp[i]);
    mon_en = 0; rsp_ready = 0;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
